// File: rtl/madd_scheduler.sv
// rtl/madd_scheduler.sv - round-robin scheduler for a shared two-stage multiply-add unit
//
// Four requesters share one pipelined b = a*c + d unit. Each requester has its own
// runtime-writable coefficient pair {c, d}. At most one operation is issued per cycle,
// and its result appears two cycles after the grant, tagged with the requester index.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        per-requester request, bit i = requester i
//   a_bus      operands, requester i at a_bus[i*WIDTH +: WIDTH]
//   cfg_we     coefficient write strobe
//   cfg_sel    requester whose coefficients are written
//   cfg_c      new c value
//   cfg_d      new d value
//   grant      combinational one-hot (or zero) grant; operand is sampled this cycle
//   out_valid  registered result valid, high for exactly one cycle per result
//   out_id     requester index of the result
//   out_b      result a*c + d, 2*WIDTH bits, unsigned
module madd_scheduler #(
  parameter int WIDTH     = 4,
  parameter int C_DEFAULT = 4,
  parameter int D_DEFAULT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_bus,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [WIDTH-1:0]     cfg_c,
  input  logic [WIDTH-1:0]     cfg_d,
  output logic [3:0]           grant,
  output logic                 out_valid,
  output logic [1:0]           out_id,
  output logic [2*WIDTH-1:0]   out_b
);

  // Coefficient file, one {c, d} entry per requester.
  logic [WIDTH-1:0] coef_c [4];
  logic [WIDTH-1:0] coef_d [4];

  // Round-robin pointer: the requester scanned first in the current cycle.
  logic [1:0] ptr;

  // Arbiter result.
  logic       gnt_any;
  logic [1:0] gnt_id;

  // Issue-side datapath.
  logic [WIDTH-1:0]   a_sel;
  logic [2*WIDTH-1:0] product;

  // Stage 1 registers.
  logic               s1_valid;
  logic [1:0]         s1_id;
  logic [2*WIDTH-1:0] s1_prod;
  logic [WIDTH-1:0]   s1_d;

  // Arbiter: depends only on req, ptr and reset, so configuration writes can never
  // create a combinational path into grant.
  always_comb begin
    logic [1:0] idx;
    gnt_any = 1'b0;
    gnt_id  = 2'd0;
    idx     = 2'd0;
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  assign grant = gnt_any ? (4'b0001 << gnt_id) : 4'b0000;

  // Operand and coefficient selection use the pre-edge coefficient values, so a
  // same-cycle write to the granted entry only affects later grants.
  assign a_sel   = a_bus[gnt_id*WIDTH +: WIDTH];
  assign product = {{WIDTH{1'b0}}, a_sel} * {{WIDTH{1'b0}}, coef_c[gnt_id]};

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        coef_c[i] <= WIDTH'(C_DEFAULT);
        coef_d[i] <= WIDTH'(D_DEFAULT);
      end
      s1_valid  <= 1'b0;
      s1_id     <= 2'd0;
      s1_prod   <= '0;
      s1_d      <= '0;
      out_valid <= 1'b0;
      out_id    <= 2'd0;
      out_b     <= '0;
    end else begin
      if (gnt_any) begin
        ptr <= gnt_id + 2'd1;
      end
      if (cfg_we) begin
        coef_c[cfg_sel] <= cfg_c;
        coef_d[cfg_sel] <= cfg_d;
      end

      // Stage 1: product, offset and tag of the operation granted this cycle.
      s1_valid <= gnt_any;
      s1_id    <= gnt_id;
      s1_prod  <= product;
      s1_d     <= coef_d[gnt_id];

      // Stage 2: final add. The sum cannot exceed 2*WIDTH bits for unsigned operands.
      out_valid <= s1_valid;
      out_id    <= s1_id;
      out_b     <= s1_prod + {{WIDTH{1'b0}}, s1_d};
    end
  end

endmodule

// File: tb/tb_madd_scheduler.sv
// tb/tb_madd_scheduler.sv - self-checking bench for madd_scheduler
`timescale 1ns/1ps

module tb_madd_scheduler;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] a_bus;
  logic           cfg_we;
  logic [1:0]     cfg_sel;
  logic [W-1:0]   cfg_c;
  logic [W-1:0]   cfg_d;
  logic [3:0]     grant;
  logic           out_valid;
  logic [1:0]     out_id;
  logic [2*W-1:0] out_b;

  madd_scheduler #(.WIDTH(W), .C_DEFAULT(4), .D_DEFAULT(3)) dut (
    .clk(clk), .reset(reset), .req(req), .a_bus(a_bus),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_c(cfg_c), .cfg_d(cfg_d),
    .grant(grant), .out_valid(out_valid), .out_id(out_id), .out_b(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: coefficient table, pointer, and a queue of promised results.
  typedef struct {
    int due;
    int id;
    int b;
  } exp_t;

  exp_t q[$];
  int   m_ptr;
  int   m_c [4];
  int   m_d [4];
  int   cyc;

  // One clock cycle. Inputs are already driven; exp_g >= 0 adds an explicit grant check.
  task automatic step(input int exp_g);
    int g;
    int idx;
    int a;
    #4;
    g = -1;
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && req[idx]) g = idx;
      end
    end
    check("grant", 32'(grant), (g < 0) ? 32'd0 : 32'(1 << g));
    if (exp_g >= 0) check("grant_dir", 32'(grant), 32'(exp_g));
    if (g >= 0) begin
      a = int'((a_bus >> (W * g)) & 16'hF);
      q.push_back('{cyc + 2, g, a * m_c[g] + m_d[g]});
    end
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_ptr = 0;
      for (int i = 0; i < 4; i++) begin
        m_c[i] = 4;
        m_d[i] = 3;
      end
      q.delete();
    end else begin
      if (g >= 0) m_ptr = (g + 1) % 4;
      if (cfg_we) begin
        m_c[cfg_sel] = int'(cfg_c);
        m_d[cfg_sel] = int'(cfg_d);
      end
    end
    #1;
    if (reset) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_id", 32'(out_id), 32'd0);
      check("rst_b", 32'(out_b), 32'd0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_id", 32'(out_id), 32'(q[0].id));
      check("out_b", 32'(out_b), 32'(q[0].b));
      void'(q.pop_front());
    end else begin
      check("idle_valid", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic idle_inputs();
    req    = 4'b0000;
    cfg_we = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'b0000;
    a_bus   = '0;
    cfg_we  = 1'b0;
    cfg_sel = 2'd0;
    cfg_c   = '0;
    cfg_d   = '0;
    cyc     = 0;
    m_ptr   = 0;
    for (int i = 0; i < 4; i++) begin
      m_c[i] = 4;
      m_d[i] = 3;
    end

    // Reset with requests pending: grant must stay zero.
    req = 4'b1111;
    step(0);
    step(0);
    reset = 1'b0;
    idle_inputs();
    step(-1);

    // Default coefficients: 5*4+3 = 23.
    req   = 4'b0001;
    a_bus = 16'h0005;
    step(4'b0001);
    idle_inputs();
    step(-1);
    check("dflt_valid", 32'(out_valid), 32'd1);
    check("dflt_id", 32'(out_id), 32'd0);
    check("dflt_b", 32'(out_b), 32'd23);
    step(-1);
    check("dflt_drop", 32'(out_valid), 32'd0);

    // Skip pattern starting at ptr=1.
    req = 4'b1001;
    step(4'b1000);
    step(4'b0001);
    step(4'b1000);
    idle_inputs();
    step(-1);
    step(-1);

    // Round-robin fairness from ptr=0.
    req   = 4'b1111;
    a_bus = 16'h4321;
    for (int i = 0; i < 6; i++) step(1 << (i % 4));
    idle_inputs();
    step(-1);
    step(-1);

    // Max-range arithmetic.
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_c = 4'd15; cfg_d = 4'd15;
    step(-1);
    cfg_we = 1'b0;
    req    = 4'b0100;
    a_bus  = 16'h0F00;
    step(4'b0100);
    a_bus  = 16'h0000;
    step(4'b0100);
    check("max_b", 32'(out_b), 32'd240);
    idle_inputs();
    step(-1);
    check("zero_b", 32'(out_b), 32'd15);
    step(-1);

    // Config/issue collision on requester 1.
    req    = 4'b0010;
    a_bus  = 16'h0020;
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_c = 4'd7; cfg_d = 4'd1;
    step(4'b0010);
    cfg_we = 1'b0;
    step(4'b0010);
    check("coll_old", 32'(out_b), 32'd11);
    idle_inputs();
    step(-1);
    check("coll_new", 32'(out_b), 32'd15);
    step(-1);

    // Reset mid-flight.
    req = 4'b0001;
    step(-1);
    req = 4'b0010;
    step(-1);
    req   = 4'b0011;
    reset = 1'b1;
    step(0);
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step(-1);
      check("flush_valid", 32'(out_valid), 32'd0);
    end
    req   = 4'b1111;
    a_bus = 16'h0001;
    step(4'b0001);
    idle_inputs();
    step(-1);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_b", 32'(out_b), 32'd7);
    step(-1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req     = 4'($urandom_range(0, 15));
      a_bus   = 16'($urandom);
      cfg_we  = ($urandom_range(0, 3) == 0);
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_c   = 4'($urandom_range(0, 15));
      cfg_d   = 4'($urandom_range(0, 15));
      reset   = ($urandom_range(0, 39) == 0);
      step(-1);
    end
    reset = 1'b0;
    idle_inputs();
    step(-1);
    step(-1);
    step(-1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
